// File: rtl/crc32_comb.sv
// Ethernet CRC-32 (reflected) with a single-cycle combinational fold of one
// GMII byte or one MII nibble per clock; result is the complemented register.
module crc32_comb #(
  parameter int                  datalen = 8,
  parameter int                  crc_len = 32,
  parameter logic [crc_len-1:0]  crc     = 32'h04C11DB7,
  parameter bit                  GMII    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt,
  input  logic [datalen-1:0]   data,
  input  logic                 updatecrc,
  output logic [crc_len-1:0]   result
);

  function automatic logic [crc_len-1:0] reflect(input logic [crc_len-1:0] v);
    logic [crc_len-1:0] r;
    r = '0;
    for (int i = 0; i < crc_len; i++) r[i] = v[crc_len-1-i];
    return r;
  endfunction

  localparam logic [crc_len-1:0] POLY_R = reflect(crc);
  localparam int                 NBITS  = GMII ? datalen : 4;

  logic [crc_len-1:0] r_crc_reg;
  logic [crc_len-1:0] w_next;
  logic               w_fb;

  // LSB-first shift: each input bit is XORed against the outgoing LSB
  always_comb begin
    w_next = r_crc_reg;
    w_fb   = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      w_fb   = w_next[0] ^ data[i];
      w_next = w_next >> 1;
      if (w_fb) w_next = w_next ^ POLY_R;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_crc_reg <= '1;
    else if (strt)      r_crc_reg <= '1;
    else if (updatecrc) r_crc_reg <= w_next;
  end

  assign result = ~r_crc_reg;

endmodule

// File: tb/tb_crc32_comb.sv
// Directed bench for crc32_comb: one GMII instance and one MII instance
// sharing clock and reset, checked against known CRC-32/ISO-HDLC values.
module tb_crc32_comb;

  logic        clk;
  logic        rst;
  logic        g_strt, g_upd;
  logic [7:0]  g_data;
  logic [31:0] g_result;
  logic        m_strt, m_upd;
  logic [7:0]  m_data;
  logic [31:0] m_result;

  int checks   = 0;
  int failures = 0;

  logic [7:0] check_str [9];

  crc32_comb #(.datalen(8), .crc_len(32), .crc(32'h04C11DB7), .GMII(1'b1)) u_gmii (
    .clk(clk), .rst(rst), .strt(g_strt), .data(g_data),
    .updatecrc(g_upd), .result(g_result)
  );

  crc32_comb #(.datalen(8), .crc_len(32), .crc(32'h04C11DB7), .GMII(1'b0)) u_mii (
    .clk(clk), .rst(rst), .strt(m_strt), .data(m_data),
    .updatecrc(m_upd), .result(m_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic g_restart();
    @(negedge clk);
    g_strt = 1'b1; g_upd = 1'b0;
    @(negedge clk);
    g_strt = 1'b0;
  endtask

  task automatic g_feed(input logic [7:0] b);
    @(negedge clk);
    g_data = b; g_upd = 1'b1;
  endtask

  task automatic g_stop();
    @(negedge clk);
    g_upd = 1'b0; g_data = 8'($urandom);
  endtask

  task automatic g_feed_check_str();
    for (int i = 0; i < 9; i++) g_feed(check_str[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (g_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", g_result, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (g_result !== 32'h0 || m_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h/%h exp=%h", g_result, m_result, 32'h0);
    end
  endtask

  task automatic test_check_string();
    g_restart();
    g_feed_check_str();
    g_stop();
    checks++;
    if (g_result !== 32'hCBF43926) begin
      failures++;
      $display("FAIL gmii_check_string got=%h exp=%h", g_result, 32'hCBF43926);
    end
  endtask

  task automatic test_single_byte_hold();
    int bad;
    g_restart();
    g_feed(8'h00);
    g_stop();
    checks++;
    if (g_result !== 32'hD202EF8D) begin
      failures++;
      $display("FAIL single_zero_byte got=%h exp=%h", g_result, 32'hD202EF8D);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      g_data = 8'($urandom);
      checks++;
      if (g_result !== 32'hD202EF8D) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL hold_cycle_%0d got=%h exp=%h", i, g_result, 32'hD202EF8D);
      end
    end
  endtask

  task automatic test_restart();
    g_restart();
    for (int i = 0; i < 4; i++) g_feed(check_str[i]);
    @(negedge clk);
    g_strt = 1'b1; g_upd = 1'b1; g_data = 8'h35;
    @(negedge clk);
    g_strt = 1'b0; g_upd = 1'b0;
    checks++;
    if (g_result !== 32'h0) begin
      failures++;
      $display("FAIL restart_drops_word got=%h exp=%h", g_result, 32'h0);
    end
    g_feed_check_str();
    g_stop();
    checks++;
    if (g_result !== 32'hCBF43926) begin
      failures++;
      $display("FAIL restart_then_string got=%h exp=%h", g_result, 32'hCBF43926);
    end
    // strt alone (no update) must also reinitialise
    g_restart();
    checks++;
    if (g_result !== 32'h0) begin
      failures++;
      $display("FAIL strt_only got=%h exp=%h", g_result, 32'h0);
    end
  endtask

  task automatic test_residue();
    g_restart();
    g_feed_check_str();
    g_feed(8'h26); g_feed(8'h39); g_feed(8'hF4); g_feed(8'hCB);
    g_stop();
    checks++;
    if (g_result !== 32'h2144DF1C) begin
      failures++;
      $display("FAIL residue got=%h exp=%h", g_result, 32'h2144DF1C);
    end
  endtask

  task automatic test_async_reset_midframe();
    g_restart();
    for (int i = 0; i < 5; i++) g_feed(check_str[i]);
    g_stop();
    checks++;
    if (g_result === 32'h0) begin
      failures++;
      $display("FAIL midframe_nonzero got=%h exp=nonzero", g_result);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (g_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_midframe got=%h exp=%h", g_result, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (g_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_then_hold got=%h exp=%h", g_result, 32'h0);
    end
  endtask

  task automatic m_feed(input logic [7:0] b);
    @(negedge clk);
    m_data = {4'($urandom), b[3:0]}; m_upd = 1'b1;
    @(negedge clk);
    m_data = {4'($urandom), b[7:4]}; m_upd = 1'b1;
  endtask

  task automatic test_mii();
    @(negedge clk);
    m_strt = 1'b1; m_upd = 1'b0;
    @(negedge clk);
    m_strt = 1'b0;
    for (int i = 0; i < 9; i++) m_feed(check_str[i]);
    @(negedge clk);
    m_upd = 1'b0;
    checks++;
    if (m_result !== 32'hCBF43926) begin
      failures++;
      $display("FAIL mii_check_string got=%h exp=%h", m_result, 32'hCBF43926);
    end
    @(negedge clk);
    m_strt = 1'b1;
    @(negedge clk);
    m_strt = 1'b0;
    m_feed(8'h00);
    @(negedge clk);
    m_upd = 1'b0;
    checks++;
    if (m_result !== 32'hD202EF8D) begin
      failures++;
      $display("FAIL mii_zero_byte got=%h exp=%h", m_result, 32'hD202EF8D);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) check_str[i] = 8'h31 + 8'(i);
    rst = 1'b1;
    g_strt = 1'b0; g_upd = 1'b0; g_data = 8'h00;
    m_strt = 1'b0; m_upd = 1'b0; m_data = 8'h00;
    test_reset();
    test_check_string();
    test_single_byte_hold();
    test_restart();
    test_residue();
    test_async_reset_midframe();
    test_mii();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
